// File: rtl/wb_halt_controller_pkg.sv
// Shared types for the write-back halt sequencer.
// Datapath width, halt FSM states and the default drain timeout.
package wb_halt_controller_pkg;

    localparam int DATA         = 32;
    localparam int HALT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } halt_state_t;

endpackage

// File: rtl/wb_halt_controller_sat_counter.sv
// Saturating up-counter used for end-of-run statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/wb_halt_controller.sv
// Orderly pipeline shutdown around WB: freeze fetch on HALT in ID,
// drain, and flag completion (or timeout) when HALT retires.
module wb_halt_controller #(
    parameter int DATA    = wb_halt_controller_pkg::DATA,
    parameter int TIMEOUT = wb_halt_controller_pkg::HALT_TIMEOUT,
    parameter int TO_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_halt,
    input  logic            stall_in,
    input  logic            wb_valid,
    input  logic            wb_halt,
    output logic            fetch_stall,
    output logic            if_flush,
    output logic            halt_done,
    output logic            halt_error,
    output logic [DATA-1:0] cycle_count,
    output logic [DATA-1:0] instr_count,
    output logic [DATA-1:0] stall_count
);

    import wb_halt_controller_pkg::*;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    halt_state_t     state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            halt_done_q, halt_done_d;
    logic            halt_error_q, halt_error_d;
    logic            if_flush_q, if_flush_d;

    logic accept;
    logic retire_halt;
    logic active;

    assign accept      = (state_q == RUN) & id_halt & ~stall_in;
    assign retire_halt = wb_valid & wb_halt;
    assign active      = (state_q != HALTED);

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        halt_done_d  = halt_done_q;
        halt_error_d = halt_error_q;
        if_flush_d   = 1'b0;
        unique case (state_q)
            RUN: begin
                // A HALT retiring without having been accepted wins over accept
                if (retire_halt) begin
                    state_d      = HALTED;
                    halt_done_d  = 1'b1;
                    halt_error_d = 1'b1;
                end else if (accept) begin
                    state_d    = DRAIN;
                    if_flush_d = 1'b1;
                end
            end
            DRAIN: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (retire_halt) begin
                    state_d     = HALTED;
                    halt_done_d = 1'b1;
                end else if (to_cnt_d == TO_MAX) begin
                    state_d      = HALTED;
                    halt_done_d  = 1'b1;
                    halt_error_d = 1'b1;
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            to_cnt_q     <= '0;
            halt_done_q  <= 1'b0;
            halt_error_q <= 1'b0;
            if_flush_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            halt_done_q  <= halt_done_d;
            halt_error_q <= halt_error_d;
            if_flush_q   <= if_flush_d;
        end
    end

    assign fetch_stall = stall_in | accept | (state_q != RUN);
    assign if_flush    = if_flush_q;
    assign halt_done   = halt_done_q;
    assign halt_error  = halt_error_q;

    sat_counter #(.W(DATA)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (active),
        .q     (cycle_count)
    );

    sat_counter #(.W(DATA)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (active & wb_valid),
        .q     (instr_count)
    );

    sat_counter #(.W(DATA)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((state_q == RUN) & stall_in),
        .q     (stall_count)
    );

endmodule

// File: tb/tb_wb_halt_controller.sv
// Directed bench for wb_halt_controller: halt sequencing,
// stalls, drain timeout, illegal retire, reset and saturation.
module tb_wb_halt_controller;

    logic        clk;
    logic        rst_n;
    logic        id_halt;
    logic        stall_in;
    logic        wb_valid;
    logic        wb_halt;
    logic        fetch_stall;
    logic        if_flush;
    logic        halt_done;
    logic        halt_error;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [31:0] stall_count;

    int n_checks;
    int n_fail;

    wb_halt_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_halt     (id_halt),
        .stall_in    (stall_in),
        .wb_valid    (wb_valid),
        .wb_halt     (wb_halt),
        .fetch_stall (fetch_stall),
        .if_flush    (if_flush),
        .halt_done   (halt_done),
        .halt_error  (halt_error),
        .cycle_count (cycle_count),
        .instr_count (instr_count),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        id_halt  = 1'b0;
        stall_in = 1'b0;
        wb_valid = 1'b0;
        wb_halt  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();

        // 1: async reset mid-stream
        wb_valid = 1'b1;
        tick(3);
        rst_n    = 1'b0;
        stall_in = 1'b1;
        wb_valid = 1'b0;
        #1;
        check("rst_fetch_stall_hi", {31'd0, fetch_stall}, 32'd1);
        check("rst_if_flush", {31'd0, if_flush}, 32'd0);
        check("rst_halt_done", {31'd0, halt_done}, 32'd0);
        check("rst_halt_error", {31'd0, halt_error}, 32'd0);
        check("rst_cycle", cycle_count, 32'd0);
        check("rst_instr", instr_count, 32'd0);
        check("rst_stall", stall_count, 32'd0);
        stall_in = 1'b0;
        #1;
        check("rst_fetch_stall_lo", {31'd0, fetch_stall}, 32'd0);
        do_reset();

        // 2: normal halt after 10 retirements
        wb_valid = 1'b1;
        tick(10);
        wb_valid = 1'b0;
        id_halt  = 1'b1;
        #1;
        check("t2_fetch_stall_accept", {31'd0, fetch_stall}, 32'd1);
        tick(1);
        id_halt = 1'b0;
        check("t2_if_flush_on", {31'd0, if_flush}, 32'd1);
        check("t2_fetch_stall_drain", {31'd0, fetch_stall}, 32'd1);
        tick(1);
        check("t2_if_flush_off", {31'd0, if_flush}, 32'd0);
        tick(2);
        check("t2_not_done_yet", {31'd0, halt_done}, 32'd0);
        wb_valid = 1'b1;
        wb_halt  = 1'b1;
        tick(1);
        wb_valid = 1'b0;
        wb_halt  = 1'b0;
        check("t2_halt_done", {31'd0, halt_done}, 32'd1);
        check("t2_halt_error", {31'd0, halt_error}, 32'd0);
        check("t2_instr", instr_count, 32'd11);
        check("t2_cycle", cycle_count, 32'd15);
        wb_valid = 1'b1;
        stall_in = 1'b1;
        tick(3);
        wb_valid = 1'b0;
        stall_in = 1'b0;
        check("t2_instr_frozen", instr_count, 32'd11);
        check("t2_cycle_frozen", cycle_count, 32'd15);
        check("t2_stall_frozen", stall_count, 32'd0);
        check("t2_done_sticky", {31'd0, halt_done}, 32'd1);

        // 3: HALT held in ID by a stall
        do_reset();
        id_halt  = 1'b1;
        stall_in = 1'b1;
        #1;
        check("t3_fetch_stall", {31'd0, fetch_stall}, 32'd1);
        tick(3);
        check("t3_stall_count", stall_count, 32'd3);
        check("t3_no_flush", {31'd0, if_flush}, 32'd0);
        stall_in = 1'b0;
        #1;
        check("t3_accept_stall", {31'd0, fetch_stall}, 32'd1);
        tick(1);
        id_halt = 1'b0;
        check("t3_if_flush", {31'd0, if_flush}, 32'd1);
        stall_in = 1'b1;
        tick(1);
        stall_in = 1'b0;
        check("t3_stall_drain", stall_count, 32'd3);
        check("t3_if_flush_off", {31'd0, if_flush}, 32'd0);

        // 4: drain timeout
        do_reset();
        id_halt = 1'b1;
        tick(1);
        id_halt = 1'b0;
        tick(15);
        check("t4_not_done_15", {31'd0, halt_done}, 32'd0);
        tick(1);
        check("t4_done", {31'd0, halt_done}, 32'd1);
        check("t4_error", {31'd0, halt_error}, 32'd1);
        check("t4_cycle", cycle_count, 32'd17);
        tick(3);
        check("t4_cycle_frozen", cycle_count, 32'd17);

        // 5: HALT retires in RUN, beating a same-cycle accept
        do_reset();
        id_halt  = 1'b1;
        wb_valid = 1'b1;
        wb_halt  = 1'b1;
        tick(1);
        id_halt  = 1'b0;
        wb_valid = 1'b0;
        wb_halt  = 1'b0;
        check("t5_done", {31'd0, halt_done}, 32'd1);
        check("t5_error", {31'd0, halt_error}, 32'd1);
        check("t5_no_flush", {31'd0, if_flush}, 32'd0);
        check("t5_instr", instr_count, 32'd1);

        // 5b: reset while draining
        do_reset();
        id_halt  = 1'b1;
        wb_valid = 1'b1;
        tick(1);
        id_halt = 1'b0;
        tick(2);
        wb_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t5b_cycle", cycle_count, 32'd0);
        check("t5b_instr", instr_count, 32'd0);
        check("t5b_fetch_stall", {31'd0, fetch_stall}, 32'd0);
        check("t5b_flush", {31'd0, if_flush}, 32'd0);
        do_reset();
        id_halt = 1'b1;
        #1;
        check("t5b_run_accept", {31'd0, fetch_stall}, 32'd1);
        id_halt = 1'b0;
        #1;
        check("t5b_run_idle", {31'd0, fetch_stall}, 32'd0);

        // 6: cycle counter saturation
        do_reset();
        tick(1);
        force dut.u_cycle_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_cycle_cnt.cnt_q;
        tick(1);
        check("t6_sat_1", cycle_count, 32'hFFFF_FFFF);
        tick(2);
        check("t6_sat_3", cycle_count, 32'hFFFF_FFFF);
        check("t6_instr", instr_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
